// File: rtl/mini_risc_pkg.sv
// Shared types and constants for the MINI-RISC pipeline sequencer.
// Holds the sequencer state enum, the stage-enable bundle, the per-cycle
// control bundle and the fixed-priority run-rule helper used by
// pipe_stage_ctrl.
package mini_risc_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_t;

  // Number of Execute/Writeback cycles let through after HALT is decoded.
  localparam int DRAIN_CYCLES = 2;

  // Counter widths for the memory wait timer and the drain counter.
  localparam int WAIT_CNT_W  = 8;
  localparam int DRAIN_CNT_W = 2;

  // One enable per pipeline register stage.
  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic w;
  } stage_en_t;

  localparam stage_en_t EN_ALL    = '{f: 1'b1, d: 1'b1, e: 1'b1, w: 1'b1};
  localparam stage_en_t EN_NONE   = '{f: 1'b0, d: 1'b0, e: 1'b0, w: 1'b0};
  localparam stage_en_t EN_BUBBLE = '{f: 1'b0, d: 1'b0, e: 1'b1, w: 1'b1};

  // Everything the sequencer drives into the datapath in one cycle.
  typedef struct packed {
    stage_en_t en;
    logic      bubble;
    logic      kill;
    logic      redirect;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN      = '{en: EN_ALL,    bubble: 1'b0, kill: 1'b0, redirect: 1'b0};
  localparam ctrl_t CTRL_FREEZE   = '{en: EN_NONE,   bubble: 1'b0, kill: 1'b0, redirect: 1'b0};
  localparam ctrl_t CTRL_BUBBLE   = '{en: EN_BUBBLE, bubble: 1'b1, kill: 1'b0, redirect: 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{en: EN_ALL,    bubble: 1'b0, kill: 1'b1, redirect: 1'b1};

  // Result of the hazard run rules: datapath control plus "start draining".
  typedef struct packed {
    ctrl_t ctrl;
    logic  to_drain;
  } rule_t;

  // Hazard rules below the memory freeze, highest priority first.
  // Stall beats flush: the branch operands in Decode are not valid yet and
  // the hazard unit re-raises flush_req once the stall is gone.
  function automatic rule_t run_rules(input logic stall, input logic flush,
                                      input logic halt);
    rule_t r;
    r.ctrl     = CTRL_RUN;
    r.to_drain = 1'b0;
    if (stall) begin
      r.ctrl = CTRL_BUBBLE;
    end else if (flush) begin
      r.ctrl = CTRL_REDIRECT;
    end else if (halt) begin
      r.ctrl     = CTRL_BUBBLE;
      r.to_drain = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones,
// clears on asynchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step on inc unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Central sequencer for the MINI-RISC four-stage pipeline.
// Resolves load-use stall, branch/jump flush, data-memory wait and halt each
// cycle and drives the stage enables, Execute bubble, Decode kill and PC
// redirect (Mealy outputs from state and inputs).
// Optional feature macro: PIPE_STAGE_CTRL_PERF_EN adds the stall_cycles and
// flush_count performance counters; without it those ports do not exist.
//
// Memory handshake: mem_req_E marks an Execute-stage data-memory access this
// cycle; the access completes in the cycle mem_ready is high. Every cycle the
// access is outstanding without mem_ready freezes all four stages. Once a
// wait has begun the sequencer only watches mem_ready, and the wait aborts
// into HALTED with mem_err set when MEM_TIMEOUT wait cycles pass unserved.
module pipe_stage_ctrl
  import mini_risc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             halt_D,
  input  logic             mem_req_E,
  input  logic             mem_ready,
  output logic             en_F,
  output logic             en_D,
  output logic             en_E,
  output logic             en_W,
  output logic             bubble_E,
  output logic             kill_D,
  output logic             pc_redirect,
  output logic             halted,
`ifdef PIPE_STAGE_CTRL_PERF_EN
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`else
  output logic             mem_err
`endif
);

  // Reject configurations the wait timer or counters cannot represent.
  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_cfg
    $error("pipe_stage_ctrl: illegal MEM_TIMEOUT or CNT_W");
  end

  localparam logic [WAIT_CNT_W-1:0]  TIMEOUT_V  = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0]  WAIT_ONE   = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = {{(DRAIN_CNT_W-1){1'b0}}, 1'b1};

  pipe_state_t             state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DRAIN_CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic                    mem_err_q, mem_err_d;

  rule_t                   rr;
  ctrl_t                   ctrl;
  logic                    mem_stall;
  logic [WAIT_CNT_W-1:0]   wait_inc;
  logic                    wait_expired;

  // Hazard rule evaluation and memory-wait bookkeeping shared by all states.
  always_comb begin
    rr           = run_rules(stall_req, flush_req, halt_D);
    mem_stall    = mem_req_E && !mem_ready;
    // wait_inc counts the current cycle, so expiry fires on the
    // MEM_TIMEOUT-th frozen cycle and HALTED follows on the next one.
    wait_inc     = wait_cnt_q + WAIT_ONE;
    wait_expired = (wait_inc == TIMEOUT_V);
  end

  // Next state, timers and Mealy control outputs.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    drain_cnt_d = drain_cnt_q;
    mem_err_d   = mem_err_q;
    ctrl        = CTRL_FREEZE;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          // First wait cycle is already spent here.
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          ctrl = rr.ctrl;
          if (rr.to_drain) begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end
        end
      end

      MEM_WAIT: begin
        if (!mem_ready) begin
          wait_cnt_d = wait_inc;
          if (wait_expired) begin
            mem_err_d = 1'b1;
            state_d   = HALTED;
          end
        end else begin
          // Access completes: the hazard rules take effect this same cycle.
          ctrl = rr.ctrl;
          if (rr.to_drain) begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end else begin
            state_d = RUN;
          end
        end
      end

      DRAIN: begin
        // Stall, flush and halt requests are ignored while draining; a
        // memory freeze holds the drain count but keeps the timeout running.
        if (mem_stall) begin
          wait_cnt_d = wait_inc;
          if (wait_expired) begin
            mem_err_d = 1'b1;
            state_d   = HALTED;
          end
        end else begin
          ctrl        = CTRL_BUBBLE;
          drain_cnt_d = drain_cnt_q - DRAIN_ONE;
          if (drain_cnt_q == DRAIN_ONE) begin
            state_d = HALTED;
          end
        end
      end

      HALTED: begin
        ctrl = CTRL_FREEZE;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, timers and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Everything is forced low while reset is held.
  assign en_F        = ctrl.en.f     & rst_n;
  assign en_D        = ctrl.en.d     & rst_n;
  assign en_E        = ctrl.en.e     & rst_n;
  assign en_W        = ctrl.en.w     & rst_n;
  assign bubble_E    = ctrl.bubble   & rst_n;
  assign kill_D      = ctrl.kill     & rst_n;
  assign pc_redirect = ctrl.redirect & rst_n;
  assign halted      = (state_q == HALTED) & rst_n;
  assign mem_err     = mem_err_q & rst_n;

`ifdef PIPE_STAGE_CTRL_PERF_EN
  logic stall_inc;
  logic flush_inc;

  // Decode-frozen cycles outside HALTED, and redirect cycles.
  assign stall_inc = !ctrl.en.d && (state_q != HALTED);
  assign flush_inc = ctrl.redirect;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed scenarios plus random
// request traffic, checked every cycle against a cycle-count reference model.
module tb_pipe_stage_ctrl;

  localparam int T  = 4;
  localparam int CW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic stall_req = 1'b0, flush_req = 1'b0, halt_D = 1'b0;
  logic mem_req_E = 1'b0, mem_ready = 1'b1;
  logic en_F, en_D, en_E, en_W, bubble_E, kill_D, pc_redirect, halted, mem_err;
`ifdef PIPE_STAGE_CTRL_PERF_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .halt_D      (halt_D),
    .mem_req_E   (mem_req_E),
    .mem_ready   (mem_ready),
    .en_F        (en_F),
    .en_D        (en_D),
    .en_E        (en_E),
    .en_W        (en_W),
    .bubble_E    (bubble_E),
    .kill_D      (kill_D),
    .pc_redirect (pc_redirect),
    .halted      (halted),
`ifdef PIPE_STAGE_CTRL_PERF_EN
    .mem_err     (mem_err),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`else
    .mem_err     (mem_err)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] outs();
    return {en_F, en_D, en_E, en_W, bubble_E, kill_D, pc_redirect, halted, mem_err};
  endfunction

  // ---------------- reference model ----------------
  // m_wait: frozen cycles of the access in progress; m_drain: drain cycles left.
  bit m_halted, m_err;
  int m_drain, m_wait, m_stalls, m_flushes;

  task automatic model_reset();
    m_halted = 0; m_err = 0; m_drain = 0; m_wait = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Drive one cycle's inputs, check outputs against the model, advance model.
  task automatic apply_check(input string tag, input logic s, input logic f,
                             input logic h, input logic mr, input logic rdy);
    logic [3:0] en;
    logic bub, kil, red, hlt, err, frozen, go_halt;
    stall_req = s; flush_req = f; halt_D = h; mem_req_E = mr; mem_ready = rdy;
    #2;
    en = 4'b0000; bub = 0; kil = 0; red = 0; go_halt = 0;
    hlt = m_halted; err = m_err;
    if (!m_halted) begin
      frozen = (m_wait > 0 && m_drain == 0) ? !rdy : (mr && !rdy);
      if (frozen) begin
        m_wait = m_wait + 1;
        if (m_wait >= T) begin
          go_halt = 1;
          m_err = 1;
        end
      end else begin
        m_wait = 0;
        if (m_drain > 0) begin
          en = 4'b0011; bub = 1;
          m_drain = m_drain - 1;
          if (m_drain == 0) go_halt = 1;
        end else if (s) begin
          en = 4'b0011; bub = 1;
        end else if (f) begin
          en = 4'b1111; kil = 1; red = 1;
        end else if (h) begin
          en = 4'b0011; bub = 1;
          m_drain = 2;
        end else begin
          en = 4'b1111;
        end
      end
    end
    exp_q.push_back({en, bub, kil, red, hlt, err});
    check_eq(tag, 32'(outs()), 32'(exp_q.pop_front()));
`ifdef PIPE_STAGE_CTRL_PERF_EN
    check_eq({tag, "_stall_cnt"}, 32'(stall_cycles), 32'(m_stalls));
    check_eq({tag, "_flush_cnt"}, 32'(flush_count), 32'(m_flushes));
    if (!hlt && !en[2] && m_stalls < (2**CW - 1)) m_stalls++;
    if (red && m_flushes < (2**CW - 1)) m_flushes++;
`endif
    if (go_halt) m_halted = 1;
  endtask

  task automatic cycle(input string tag, input logic s, input logic f,
                       input logic h, input logic mr, input logic rdy);
    apply_check(tag, s, f, h, mr, rdy);
    @(negedge clk);
  endtask

  // Hold reset for a clock edge with random inputs; outputs must stay low.
  task automatic do_reset();
    rst_n = 1'b0;
    stall_req = 1'($urandom); flush_req = 1'($urandom); halt_D = 1'($urandom);
    mem_req_E = 1'($urandom); mem_ready = 1'($urandom);
    #2;
    check_eq("reset_outs", 32'(outs()), 32'd0);
    model_reset();
`ifdef PIPE_STAGE_CTRL_PERF_EN
    check_eq("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    check_eq("reset_flush_cnt", 32'(flush_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) cycle("idle", 0, 0, 0, 0, 1);

    cycle("stall", 1, 0, 0, 0, 1);
    cycle("after_stall", 0, 0, 0, 0, 1);
`ifdef PIPE_STAGE_CTRL_PERF_EN
    check_eq("stall_cycles_one", 32'(stall_cycles), 32'd1);
`endif

    cycle("stall_flush", 1, 1, 0, 0, 1);
    cycle("flush", 0, 1, 0, 0, 1);
    cycle("after_flush", 0, 0, 0, 0, 1);
`ifdef PIPE_STAGE_CTRL_PERF_EN
    check_eq("flush_count_one", 32'(flush_count), 32'd1);
`endif

    for (int i = 0; i < 3; i++) cycle("mem_wait", 0, 0, 0, 1, 0);
    cycle("mem_ready", 0, 0, 0, 1, 1);
    cycle("after_mem", 0, 0, 0, 0, 1);

    // Memory never answers: timeout into HALTED with sticky error.
    do_reset();
    for (int i = 0; i < T; i++) cycle("mem_timeout", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle("timeout_halted", 1, 1, 1, 1, 1);
    check_eq("timeout_halted_flag", 32'(halted), 32'd1);
    check_eq("timeout_err_flag", 32'(mem_err), 32'd1);

    // Full halt drain.
    do_reset();
    cycle("halt", 0, 0, 1, 0, 1);
    cycle("drain1", 1, 1, 0, 0, 1);
    cycle("drain2", 0, 1, 0, 0, 1);
    cycle("halted", 0, 0, 0, 0, 1);
    check_eq("halt_flag", 32'(halted), 32'd1);

    // Reset during the second drain cycle.
    do_reset();
    cycle("halt2", 0, 0, 1, 0, 1);
    cycle("drain1b", 0, 0, 0, 0, 1);
    apply_check("drain2b", 0, 0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1 check_eq("rst_mid_drain", 32'(outs()), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 0, 0, 0, 0, 1);
    check_eq("post_rst_en", 32'({en_F, en_D, en_E, en_W}), 32'hF);

    // Random request traffic.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < 60; i++) begin
        cycle("rand",
              logic'($urandom_range(0, 5) == 0),
              logic'($urandom_range(0, 4) == 0),
              logic'($urandom_range(0, 39) == 0),
              logic'($urandom_range(0, 2) == 0),
              logic'($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
